// File: rtl/pipeline_pkg.sv
// Shared types and constants for the ARM pipeline front end.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              i_load_valid,
    input  logic [31:0]       i_instr,
    input  logic [ADDR_W-1:0] i_pc_plus8,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc_plus8,
    output logic              o_valid
);

    always_ff @(posedge clk) begin
        if (i_flush) begin
            o_instr    <= NOP_INSTR;
            o_pc_plus8 <= '0;
            o_valid    <= 1'b0;
        end else if (!i_stall) begin
            if (i_load_valid) begin
                o_instr    <= i_instr;
                o_pc_plus8 <= i_pc_plus8;
                o_valid    <= 1'b1;
            end else begin
                o_instr    <= NOP_INSTR;
                o_pc_plus8 <= '0;
                o_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipeline_fetch_stage.sv
// Instruction fetch stage: PC, redirect selection, single-outstanding imem
// handshake with a one-word hold buffer, and the IF/ID register.
module pipeline_fetch_stage
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              flushD,
    input  logic              BranchTakenE,
    input  logic [ADDR_W-1:0] ALUResultE,
    input  logic              PCSrcW,
    input  logic [ADDR_W-1:0] ResultW,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] PCF,
    output logic [31:0]       InstrF,
    output logic              fetch_busy,
    output logic [31:0]       InstrD,
    output logic [ADDR_W-1:0] PCPlus8D,
    output logic              validD
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pcf;
    logic [31:0]       r_buf;
    logic              r_pending;

    logic              w_redir;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_pc_plus8;
    logic              w_fire;
    logic [31:0]       w_instr;
    logic              w_id_flush;

    always_comb begin
        w_redir    = BranchTakenE | PCSrcW;
        w_target   = BranchTakenE ? ALUResultE : ResultW;
        w_pc_plus4 = r_pcf + ADDR_W'(4);
        w_pc_plus8 = r_pcf + ADDR_W'(8);
        // An instruction only advances into decode when fetch is not stalled.
        w_fire     = reset & ~stallF & ~w_redir &
                     (((r_state == FETCH) & imem_rvalid) | (r_state == HOLD));
        w_instr    = NOP_INSTR;
        if (reset) begin
            case (r_state)
                FETCH:   if (imem_rvalid && !w_redir) w_instr = imem_rdata;
                HOLD:    w_instr = r_buf;
                default: w_instr = NOP_INSTR;
            endcase
        end
    end

    assign imem_req   = reset & (r_state == FETCH);
    assign imem_addr  = r_pcf;
    assign PCF        = r_pcf;
    assign InstrF     = w_instr;
    // Depends only on state and rvalid, never on the hazard unit's stalls.
    assign fetch_busy = reset & (((r_state == FETCH) & ~imem_rvalid) | (r_state == DROP));
    assign w_id_flush = ~reset | flushD;

    always_ff @(posedge clk) begin
        if (!reset) begin
            // A request still in flight must have its response swallowed.
            r_state <= (r_pending && !imem_rvalid) ? DROP : FETCH;
            r_pcf   <= RESET_PC;
            r_buf   <= NOP_INSTR;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_rvalid) begin
                        if (w_redir) begin
                            r_pcf <= w_target;
                        end else if (stallF) begin
                            r_buf   <= imem_rdata;
                            r_state <= HOLD;
                        end else begin
                            r_pcf <= w_pc_plus4;
                        end
                    end else if (w_redir) begin
                        r_pcf   <= w_target;
                        r_state <= DROP;
                    end
                end
                HOLD: begin
                    if (w_redir) begin
                        r_pcf   <= w_target;
                        r_state <= FETCH;
                    end else if (!stallF) begin
                        r_pcf   <= w_pc_plus4;
                        r_state <= FETCH;
                    end
                end
                DROP: begin
                    if (w_redir) r_pcf <= w_target;
                    if (imem_rvalid) r_state <= FETCH;
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    // Tracks the memory transaction itself, so it survives reset.
    always_ff @(posedge clk) begin
        if (imem_rvalid) begin
            r_pending <= 1'b0;
        end else if (imem_req) begin
            r_pending <= 1'b1;
        end
    end

    if_id_reg #(
        .ADDR_W(ADDR_W)
    ) u_if_id (
        .clk          (clk),
        .i_flush      (w_id_flush),
        .i_stall      (stallD),
        .i_load_valid (w_fire),
        .i_instr      (w_instr),
        .i_pc_plus8   (w_pc_plus8),
        .o_instr      (InstrD),
        .o_pc_plus8   (PCPlus8D),
        .o_valid      (validD)
    );

endmodule
